imm_decode_stage: RTL and testbench

//  Registered immediate-decode pipeline stage between fetch and execute.

---
 rtl/imm_decode_stage.sv | 165 ++++++++++++++++
 tb/tb_imm_decode_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage between fetch and execute.
// Classifies each instruction into R/I/S/B/U/J (optionally Z) format and registers
// the sign-extended immediate, format code and illegal-opcode flag behind a
// valid/ready handshake. SKID=1 adds a second entry so in_ready is a flop output.
// Optional feature macro: IMMGEN_ZICSR_EN (CSR immediate instructions decode as Z format).
module imm_decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SKID = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam logic [2:0] FmtR   = 3'd0;
  localparam logic [2:0] FmtI   = 3'd1;
  localparam logic [2:0] FmtS   = 3'd2;
  localparam logic [2:0] FmtB   = 3'd3;
  localparam logic [2:0] FmtU   = 3'd4;
  localparam logic [2:0] FmtJ   = 3'd5;
  localparam logic [2:0] FmtZ   = 3'd6;
  localparam logic [2:0] FmtIll = 3'd7;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  entry_t          dec;
  entry_t          out_q, out_d;
  entry_t          skid_q, skid_d;
  logic            out_valid_q, out_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic            accept;

  // Decode the incoming word; imm starts as all sign bits and the low field is overlaid
  always_comb begin
    imm = {XLEN{in_instr[31]}};
    fmt = FmtIll;
    unique case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        fmt       = FmtI;
        imm[11:0] = in_instr[31:20];
      end
      7'b1110011: begin
`ifdef IMMGEN_ZICSR_EN
        // CSR*I forms carry a 5-bit unsigned immediate in the rs1 field
        if (in_instr[14]) begin
          fmt      = FmtZ;
          imm      = '0;
          imm[4:0] = in_instr[19:15];
        end else begin
          fmt       = FmtI;
          imm[11:0] = in_instr[31:20];
        end
`else
        fmt       = FmtI;
        imm[11:0] = in_instr[31:20];
`endif
      end
      7'b0100011: begin
        fmt       = FmtS;
        imm[11:0] = {in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        fmt       = FmtB;
        imm[12:0] = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        fmt       = FmtU;
        imm[31:0] = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        fmt       = FmtJ;
        imm[20:0] = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110011: begin
        fmt = FmtR;
        imm = '0;
      end
      default: begin
        fmt = FmtIll;
        imm = '0;
      end
    endcase
    dec.instr   = in_instr;
    dec.pc      = in_pc;
    dec.imm     = imm;
    dec.fmt     = fmt;
    dec.illegal = (fmt == FmtIll);
  end

  assign in_ready = (SKID != 0) ? !skid_valid_q : (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;

  // Next-state: refill the output slot from the skid first so order stays FIFO
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
        if (accept) begin
          skid_d       = dec;
          skid_valid_d = 1'b1;
        end
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Only reachable with SKID=1: output stalled, park the new entry
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_q.instr;
  assign out_pc      = out_q.pc;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: a 32-bit skid instance and a 64-bit single-register
// instance share the instruction stream; both are scored against a queue model.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_ready64 = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_instr, out_pc, out_imm;
  logic [2:0]  out_fmt;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [31:0] out_instr64;
  logic [63:0] out_pc64, out_imm64;
  logic [2:0]  out_fmt64;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .SKID(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  imm_decode_stage #(.XLEN(64), .SKID(0)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_instr(out_instr64),
    .out_pc(out_pc64), .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Format code straight from the opcode table
  function automatic int ref_fmt(input logic [31:0] i);
    case (i[6:0])
      7'h03, 7'h13, 7'h67: return 1;
`ifdef IMMGEN_ZICSR_EN
      7'h73: return i[14] ? 6 : 1;
`else
      7'h73: return 1;
`endif
      7'h23: return 2;
      7'h63: return 3;
      7'h37, 7'h17: return 4;
      7'h6f: return 5;
      7'h33: return 0;
      default: return 7;
    endcase
  endfunction

  // Immediate as a signed integer value, then truncated to the datapath width
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input int xlen);
    longint v;
    longint s;
    s = i[31] ? 64'sd1 : 64'sd0;
    case (ref_fmt(i))
      1: v = longint'(i[31:20]) - s * 4096;
      2: v = longint'(i[31:25]) * 32 + longint'(i[11:7]) - s * 4096;
      3: v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2
             - s * 4096;
      4: v = longint'(i[31:12]) * 4096 - s * (longint'(1) << 32);
      5: v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2
             - s * (longint'(1) << 20);
      6: v = longint'(i[19:15]);
      default: v = 0;
    endcase
    if (xlen == 32) return {32'b0, v[31:0]};
    return v;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0]  ops [11] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17,
                              7'h6f, 7'h33, 7'h7f};
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 12);
    if (k >= 11) return r;
    return {r[31:7], ops[k]};
  endfunction

  // Model of the 32-bit skid instance: a FIFO of at most two entries
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  ent_t q[$];
  int   sz;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      sz = q.size();
      check_eq("out_valid", out_valid, sz != 0);
      check_eq("in_ready", in_ready, sz < 2);
      if (sz != 0) begin
        check_eq("out_instr", out_instr, q[0].instr);
        check_eq("out_pc", out_pc, q[0].pc);
        check_eq("out_imm", out_imm, ref_imm(q[0].instr, 32));
        check_eq("out_fmt", out_fmt, ref_fmt(q[0].instr));
        check_eq("out_illegal", out_illegal, ref_fmt(q[0].instr) == 7);
      end
      if (flush) begin
        q.delete();
      end else begin
        if (out_ready && sz != 0) void'(q.pop_front());
        if (in_valid && sz < 2) q.push_back('{instr: in_instr, pc: in_pc[31:0]});
      end
    end
  end

  // Model of the 64-bit single-register instance
  logic        v64 = 1'b0;
  logic [31:0] e64_instr;
  logic [63:0] e64_pc;
  logic        rdy64;

  always @(negedge clk) begin
    if (reset) begin
      v64 = 1'b0;
    end else begin
      rdy64 = !v64 || out_ready64;
      check_eq("out_valid64", out_valid64, v64);
      check_eq("in_ready64", in_ready64, rdy64);
      if (v64) begin
        check_eq("out_instr64", out_instr64, e64_instr);
        check_eq("out_pc64", out_pc64, e64_pc);
        check_eq("out_imm64", out_imm64, ref_imm(e64_instr, 64));
        check_eq("out_fmt64", out_fmt64, ref_fmt(e64_instr));
      end
      if (flush) v64 = 1'b0;
      else if (in_valid && rdy64) begin
        v64       = 1'b1;
        e64_instr = in_instr;
        e64_pc    = in_pc;
      end else if (out_ready64) v64 = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_check(input logic [31:0] instr, input logic [31:0] exp32,
                            input logic [63:0] exp64, input int fmt, input logic ill);
    tick();
    in_valid = 1'b1; in_instr = instr; in_pc = 64'h0000_1000;
    out_ready = 1'b1; out_ready64 = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("dir_valid", out_valid, 1'b1);
    check_eq("dir_imm", out_imm, exp32);
    check_eq("dir_fmt", out_fmt, fmt);
    check_eq("dir_illegal", out_illegal, ill);
    check_eq("dir_imm64", out_imm64, exp64);
  endtask

  task automatic all_zero(input string tag);
    check_eq({tag, "_valid"}, out_valid, 1'b0);
    check_eq({tag, "_ready"}, in_ready, 1'b1);
    check_eq({tag, "_fields"}, {out_instr, out_pc, out_imm, out_fmt, out_illegal}, '0);
    check_eq({tag, "_valid64"}, out_valid64, 1'b0);
    check_eq({tag, "_ready64"}, in_ready64, 1'b1);
    check_eq({tag, "_imm64"}, out_imm64, '0);
    check_eq({tag, "_f64"}, {out_instr64, out_pc64[31:0], out_fmt64, out_illegal64}, '0);
  endtask

  logic [31:0] seen[$];
  localparam logic [31:0] InsA = 32'h00100093;
  localparam logic [31:0] InsB = 32'h00200113;
  localparam logic [31:0] InsC = 32'h00300193;

  initial begin
    #2;
    all_zero("reset");
    tick();
    reset = 1'b0;

    send_check(32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1, 1'b0);
    send_check(32'h123450B7, 32'h12345000, 64'h00000000_12345000, 4, 1'b0);
    send_check(32'h800000B7, 32'h80000000, 64'hFFFFFFFF_80000000, 4, 1'b0);
    send_check(32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3, 1'b0);
    send_check(32'h0080006F, 32'h00000008, 64'h00000000_00000008, 5, 1'b0);
    send_check(32'h0000007F, 32'h00000000, 64'h0, 7, 1'b1);
`ifdef IMMGEN_ZICSR_EN
    send_check(32'h3401D073, 32'h00000003, 64'h3, 6, 1'b0);
`else
    send_check(32'h3401D073, 32'h00000340, 64'h340, 1, 1'b0);
`endif

    // Stall and ordering through the skid entry
    tick();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = InsA;
    tick(); in_instr = InsB;
    tick(); in_instr = InsC;
    tick(); tick();
    @(negedge clk);
    check_eq("stall_ready", in_ready, 1'b0);
    check_eq("stall_head", out_instr, InsA);
    tick();
    out_ready = 1'b1;
    seen.delete();
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (out_valid && out_ready) seen.push_back(out_instr);
      if (in_valid && in_ready) begin
        tick();
        in_valid = 1'b0;
      end else begin
        tick();
      end
    end
    check_eq("order_count", seen.size(), 3);
    if (seen.size() == 3) begin
      check_eq("order_0", seen[0], InsA);
      check_eq("order_1", seen[1], InsB);
      check_eq("order_2", seen[2], InsC);
    end

    // Flush with output and skid full while a new word is offered
    out_ready = 1'b0; in_valid = 1'b1; in_instr = InsA;
    tick(); in_instr = InsB;
    tick(); in_instr = InsC; flush = 1'b1;
    @(negedge clk);
    check_eq("preflush_valid", out_valid, 1'b1);
    check_eq("preflush_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_valid", out_valid, 1'b0);
    check_eq("flush_ready", in_ready, 1'b1);
    // Flush beats an input that would otherwise be accepted
    tick();
    in_valid = 1'b1; in_instr = 32'h00400213; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check_eq("flush_drop", out_valid, 1'b0);
    end

    // Asynchronous reset while stalled with both entries occupied
    tick();
    out_ready = 1'b0; out_ready64 = 1'b0; in_valid = 1'b1; in_instr = InsA; in_pc = 64'h55;
    tick(); in_instr = InsB;
    tick(); in_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    all_zero("midreset");
    tick();
    tick();
    reset = 1'b0;

    // Randomized traffic against the models
    for (int n = 0; n < 1500; n++) begin
      tick();
      in_valid    = ($urandom_range(0, 9) < 7);
      in_instr    = gen_instr();
      in_pc       = {$urandom, $urandom};
      out_ready   = ($urandom_range(0, 9) < 6);
      out_ready64 = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 29) == 0);
    end
    tick();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; out_ready64 = 1'b1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
